// File: rtl/lane_mem_ctrl.sv
// lane_mem_ctrl: lane-enabled scratch memory with an enable-gated FSM and
// a valid/ready request port whose read responses hold under backpressure.
module lane_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W/LANE_W-1:0]   req_be,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [1:0]                 state_out,
    output logic [7:0]                 op_count
);
    localparam int NLANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, DRAIN = 2'b10} state_t;

    state_t             state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [7:0]         op_count_q, op_count_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               accept, wr_en, rd_en, rsp_free;

    assign rsp_free  = !rsp_valid_q || rsp_ready;
    assign req_ready = (state_q == ACTIVE) && rsp_free;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we;
    assign rd_en     = accept && !req_we;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rd_en ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_data_d  = rd_en ? mem_q[req_addr] : rsp_data_q;
        op_count_d  = op_count_q + 8'(accept);
        case (state_q)
            IDLE:    state_d = enable ? ACTIVE : IDLE;
            ACTIVE:  state_d = enable ? ACTIVE : (rsp_free ? IDLE : DRAIN);
            DRAIN:   state_d = rsp_ready ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < NLANES; j++) begin
                if (req_be[j]) mem_q[req_addr][j*LANE_W +: LANE_W] <= req_wdata[j*LANE_W +: LANE_W];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign state_out = state_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_lane_mem_ctrl.sv
// tb_lane_mem_ctrl: directed checks of lane writes, reads, backpressure,
// drain, counter wrap and reset behaviour of lane_mem_ctrl.
module tb_lane_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, req_valid, req_ready, req_we;
    logic [3:0]  req_addr, req_be;
    logic [15:0] req_wdata, rsp_data;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  state_out;
    logic [7:0]  op_count;
    logic [15:0] model [16];
    int          nvec = 0;
    int          nerr = 0;

    lane_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .state_out(state_out), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [15:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        cyc();
    endtask

    task automatic rd(input logic [3:0] a);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_wdata = '0;
        idle_req();
        cyc(); cyc();
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("idle_hold", 32'(state_out), 32'h0);
        enable = 1'b1;
        cyc();
        chk("to_active", 32'(state_out), 32'h1);
        chk("active_ready", 32'(req_ready), 32'h1);

        // Lane merge: ABCD then lanes 0 and 2 from 1234 gives A2C4.
        wr(4'd3, 4'b1111, 16'hABCD);
        wr(4'd3, 4'b0101, 16'h1234);
        rd(4'd3);
        idle_req();
        chk("lane_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lane_rsp_data", 32'(rsp_data), 32'hA2C4);
        chk("lane_op_count", 32'(op_count), 32'h3);
        #2;
        chk("pending_blocks_ready", 32'(req_ready), 32'h0);

        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model[i] = 16'(i * 16'h1111) ^ 16'h00F0;
            wr(4'(i), 4'b1111, model[i]);
        end
        idle_req();
        chk("fill_op_count", 32'(op_count), 32'd19);

        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i);
            #2;
            chk("b2b_ready", 32'(req_ready), 32'h1);
            @(posedge clk); #1;
            chk("b2b_valid", 32'(rsp_valid), 32'h1);
            chk("b2b_data", 32'(rsp_data), 32'(model[i]));
        end
        idle_req();
        cyc();
        chk("b2b_valid_clear", 32'(rsp_valid), 32'h0);
        chk("b2b_data_kept", 32'(rsp_data), 32'(model[15]));
        chk("b2b_op_count", 32'(op_count), 32'd35);

        // Backpressure: a second request waits unaccepted.
        rsp_ready = 1'b0;
        rd(4'd5);
        req_addr = 4'd6;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_data", 32'(rsp_data), 32'(model[5]));
            chk("bp_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        chk("bp_op_count", 32'(op_count), 32'd36);
        idle_req();
        rsp_ready = 1'b1;
        #2;
        chk("bp_ready_back", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_consumed", 32'(rsp_valid), 32'h0);
        chk("bp_data_kept", 32'(rsp_data), 32'(model[5]));

        rsp_ready = 1'b0;
        rd(4'd7);
        idle_req();
        enable = 1'b0;
        cyc();
        chk("drain_state", 32'(state_out), 32'h2);
        chk("drain_ready", 32'(req_ready), 32'h0);
        enable = 1'b1;
        cyc();
        chk("drain_ignores_enable", 32'(state_out), 32'h2);
        chk("drain_rsp_held", 32'(rsp_data), 32'(model[7]));
        rsp_ready = 1'b1;
        cyc();
        chk("drain_exit", 32'(state_out), 32'h0);
        chk("drain_rsp_clear", 32'(rsp_valid), 32'h0);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("wrap_active", 32'(state_out), 32'h1);
        for (int i = 0; i < 257; i++) wr(4'(i), 4'b0000, 16'hFFFF);
        idle_req();
        chk("wrap_op_count", 32'(op_count), 32'h01);
        rd(4'd0);
        chk("wrap_mem0", 32'(rsp_data), 32'(model[0]));
        rd(4'd15);
        chk("wrap_mem15", 32'(rsp_data), 32'(model[15]));
        idle_req();
        cyc();

        rsp_ready = 1'b0;
        rd(4'd9);
        idle_req();
        chk("mid_pending", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_state", 32'(state_out), 32'h0);
        chk("mid_rst_op", 32'(op_count), 32'h0);
        cyc();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        chk("post_rst_active", 32'(state_out), 32'h1);
        rd(4'd9);
        idle_req();
        chk("preserved_valid", 32'(rsp_valid), 32'h1);
        chk("preserved_data", 32'(rsp_data), 32'(model[9]));
        chk("post_rst_op", 32'(op_count), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
